// File: rtl/gigatron_ps2_pad.sv
// gigatron_ps2_pad
// Turns hps_io PS/2 key events into the Famicom serial pad protocol used by
// the Gigatron shell. In gamepad mode eight keys drive the eight buttons. In
// ASCII mode a typed key is presented as its ASCII byte for HOLD_LATCHES
// latch events. Output data is active low.
//
// state       | meaning
// ST_IDLE     | no frame in progress, pulses only shift in 1s
// ST_LATCHED  | latch high, shift register reloading every cycle
// ST_SHIFTING | latch released, counting the 8 data pulses
module gigatron_ps2_pad #(
    parameter int HOLD_LATCHES = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        ascii_mode,
    input  logic        famicom_latch,
    input  logic        famicom_pulse,
    output logic        famicom_data
);
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LATCHED  = 2'd1;
    localparam logic [1:0] ST_SHIFTING = 2'd2;
    localparam logic [3:0] HOLD_INIT   = 4'(HOLD_LATCHES);

    logic [2:0] latch_sync;
    logic [2:0] pulse_sync;
    logic       latch_s;
    logic       latch_rise;
    logic       latch_fall;
    logic       pulse_rise;

    logic       key_tog;
    logic       key_event;
    logic       key_pressed;
    logic       key_ext;
    logic [7:0] key_code;

    logic [7:0] btn;
    logic       shift_l;
    logic       shift_r;
    logic [7:0] ascii_code;
    logic [3:0] hold_cnt;

    logic       btn_hit;
    logic [2:0] btn_idx;
    logic [8:0] xlat;
    logic [7:0] ascii_next;
    logic [7:0] load_val;

    logic [7:0] sr;
    logic [7:0] frame_val;
    logic [1:0] state;
    logic [2:0] shift_cnt;

    // Set-2 scancode to lower-case ASCII; bit 8 flags a translatable key.
    function automatic logic [8:0] ascii_of(input logic [7:0] sc);
        logic [8:0] r;
        r = 9'h000;
        case (sc)
            8'h1C: r = 9'h161;  8'h32: r = 9'h162;  8'h21: r = 9'h163;
            8'h23: r = 9'h164;  8'h24: r = 9'h165;  8'h2B: r = 9'h166;
            8'h34: r = 9'h167;  8'h33: r = 9'h168;  8'h43: r = 9'h169;
            8'h3B: r = 9'h16A;  8'h42: r = 9'h16B;  8'h4B: r = 9'h16C;
            8'h3A: r = 9'h16D;  8'h31: r = 9'h16E;  8'h44: r = 9'h16F;
            8'h4D: r = 9'h170;  8'h15: r = 9'h171;  8'h2D: r = 9'h172;
            8'h1B: r = 9'h173;  8'h2C: r = 9'h174;  8'h3C: r = 9'h175;
            8'h2A: r = 9'h176;  8'h1D: r = 9'h177;  8'h22: r = 9'h178;
            8'h35: r = 9'h179;  8'h1A: r = 9'h17A;
            8'h45: r = 9'h130;  8'h16: r = 9'h131;  8'h1E: r = 9'h132;
            8'h26: r = 9'h133;  8'h25: r = 9'h134;  8'h2E: r = 9'h135;
            8'h36: r = 9'h136;  8'h3D: r = 9'h137;  8'h3E: r = 9'h138;
            8'h46: r = 9'h139;
            8'h29: r = 9'h120;
            8'h5A: r = 9'h10A;
            8'h66: r = 9'h17F;
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    assign latch_s    = latch_sync[1];
    assign latch_rise = latch_sync[1] & ~latch_sync[2];
    assign latch_fall = ~latch_sync[1] & latch_sync[2];
    assign pulse_rise = pulse_sync[1] & ~pulse_sync[2];

    assign key_event   = ps2_key[10] ^ key_tog;
    assign key_pressed = ps2_key[9];
    assign key_ext     = ps2_key[8];
    assign key_code    = ps2_key[7:0];

    assign famicom_data = sr[7];

    // Bring latch/pulse into clk_sys and keep one extra stage for edge detect.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            latch_sync <= 3'b000;
            pulse_sync <= 3'b000;
        end else begin
            latch_sync <= {latch_sync[1:0], famicom_latch};
            pulse_sync <= {pulse_sync[1:0], famicom_pulse};
        end
    end

    // Decode the key event into a button index, ASCII code and load value.
    always_comb begin
        btn_hit = 1'b1;
        btn_idx = 3'd0;
        case ({key_ext, key_code})
            9'h022:  btn_idx = 3'd7;
            9'h01A:  btn_idx = 3'd6;
            9'h00D:  btn_idx = 3'd5;
            9'h05A:  btn_idx = 3'd4;
            9'h175:  btn_idx = 3'd3;
            9'h172:  btn_idx = 3'd2;
            9'h16B:  btn_idx = 3'd1;
            9'h174:  btn_idx = 3'd0;
            default: btn_hit = 1'b0;
        endcase

        xlat       = ascii_of(key_code);
        ascii_next = xlat[7:0];
        if ((shift_l || shift_r) && xlat[7:0] >= 8'h61 && xlat[7:0] <= 8'h7A)
            ascii_next = xlat[7:0] - 8'h20;

        if (ascii_mode)
            load_val = (hold_cnt != 4'd0) ? ascii_code : 8'h00;
        else
            load_val = btn;
    end

    // Key event tracking; a key arriving with a latch edge wins the hold count.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            key_tog    <= ps2_key[10];
            btn        <= 8'h00;
            shift_l    <= 1'b0;
            shift_r    <= 1'b0;
            ascii_code <= 8'h00;
            hold_cnt   <= 4'd0;
        end else begin
            key_tog <= ps2_key[10];
            if (latch_rise && hold_cnt != 4'd0)
                hold_cnt <= hold_cnt - 4'd1;
            if (key_event) begin
                if (btn_hit)
                    btn[btn_idx] <= key_pressed;
                if (!key_ext && key_code == 8'h12)
                    shift_l <= key_pressed;
                if (!key_ext && key_code == 8'h59)
                    shift_r <= key_pressed;
                if (key_pressed && !key_ext && xlat[8] && ascii_mode) begin
                    ascii_code <= ascii_next;
                    hold_cnt   <= HOLD_INIT;
                end
            end
        end
    end

    // Frame sequencing: snapshot on latch edge, hold while latched, then shift.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sr        <= 8'hFF;
            frame_val <= 8'hFF;
            state     <= ST_IDLE;
            shift_cnt <= 3'd0;
        end else begin
            if (latch_rise) begin
                sr        <= ~load_val;
                frame_val <= ~load_val;
                state     <= ST_LATCHED;
                shift_cnt <= 3'd0;
            end else if (latch_s) begin
                sr <= frame_val;
            end else if (pulse_rise) begin
                sr <= {sr[6:0], 1'b1};
                if (state == ST_SHIFTING) begin
                    shift_cnt <= shift_cnt + 3'd1;
                    if (shift_cnt == 3'd7)
                        state <= ST_IDLE;
                end
            end
            if (state == ST_LATCHED && latch_fall)
                state <= ST_SHIFTING;
        end
    end
endmodule

// File: tb/tb_gigatron_ps2_pad.sv
// Scoreboard bench for gigatron_ps2_pad: the driver pushes the expected
// 10-sample serial frame from a behavioural key/pad model, the monitor
// collects what the pad shifts out and compares.
module tb_gigatron_ps2_pad;
    localparam int HOLD = 4;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] ps2_key = 11'h000;
    logic        ascii_mode = 1'b0;
    logic        famicom_latch = 1'b0;
    logic        famicom_pulse = 1'b0;
    logic        famicom_data;

    gigatron_ps2_pad #(.HOLD_LATCHES(HOLD)) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ps2_key       (ps2_key),
        .ascii_mode    (ascii_mode),
        .famicom_latch (famicom_latch),
        .famicom_pulse (famicom_pulse),
        .famicom_data  (famicom_data)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    int frame_no = 0;
    logic [9:0] exp_q[$];

    // Behavioural model state
    logic [7:0] m_btn;
    logic [7:0] m_code;
    bit         m_shl;
    bit         m_shr;
    int         m_hold;
    int         btn_bit[int];
    logic [7:0] asc_map[int];

    logic [7:0] let_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dig_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                8'h3D, 8'h3E, 8'h46};
    logic [8:0] pool [20] = '{9'h022, 9'h01A, 9'h00D, 9'h05A, 9'h175, 9'h172,
                              9'h16B, 9'h174, 9'h012, 9'h059, 9'h01C, 9'h032,
                              9'h045, 9'h016, 9'h029, 9'h066, 9'h005, 9'h15A,
                              9'h112, 9'h03A};

    function automatic void build_maps();
        btn_bit['h022] = 7; btn_bit['h01A] = 6; btn_bit['h00D] = 5; btn_bit['h05A] = 4;
        btn_bit['h175] = 3; btn_bit['h172] = 2; btn_bit['h16B] = 1; btn_bit['h174] = 0;
        for (int i = 0; i < 26; i++) asc_map[int'(let_sc[i])] = 8'h61 + 8'(i);
        for (int i = 0; i < 10; i++) asc_map[int'(dig_sc[i])] = 8'h30 + 8'(i);
        asc_map['h29] = 8'h20;
        asc_map['h5A] = 8'h0A;
        asc_map['h66] = 8'h7F;
    endfunction

    function automatic void model_reset();
        m_btn = 8'h00; m_code = 8'h00; m_shl = 0; m_shr = 0; m_hold = 0;
    endfunction

    function automatic void model_key(input bit ext, input logic [7:0] code, input bit pr);
        int key;
        logic [7:0] ch;
        key = (ext ? 256 : 0) + int'(code);
        if (btn_bit.exists(key)) m_btn[btn_bit[key]] = pr;
        if (key == 'h12) m_shl = pr;
        if (key == 'h59) m_shr = pr;
        if (pr && ascii_mode && asc_map.exists(key)) begin
            ch = asc_map[key];
            if ((m_shl || m_shr) && ch >= 8'h61 && ch <= 8'h7A) ch = ch - 8'h20;
            m_code = ch;
            m_hold = HOLD;
        end
    endfunction

    // Frame samples: position 0 before any pulse, then after pulses 1..9.
    function automatic logic [9:0] model_frame();
        logic [7:0] ld;
        if (ascii_mode) ld = (m_hold > 0) ? m_code : 8'h00;
        else            ld = m_btn;
        if (m_hold > 0) m_hold--;
        return {~ld, 2'b11};
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, act, exp);
        end
    endtask

    task automatic send_key(input bit ext, input logic [7:0] code, input bit pr);
        @(posedge clk_sys); #1;
        ps2_key = {~ps2_key[10], pr, ext, code};
        model_key(ext, code, pr);
        repeat (2) @(posedge clk_sys);
        #1;
    endtask

    task automatic run_frame(input bit do_evt, input bit ev_ext, input logic [7:0] ev_code,
                             input bit ev_pr, input int rst_after);
        logic [9:0] v;
        @(posedge clk_sys); #1;
        famicom_latch = 1'b1;
        v = model_frame();
        if (rst_after > 0) v[5:0] = 6'h3F;
        exp_q.push_back(v);
        if (do_evt) begin
            // The toggle lands in the same cycle the pad sees the latch edge.
            repeat (2) @(posedge clk_sys);
            #1;
            ps2_key = {~ps2_key[10], ev_pr, ev_ext, ev_code};
            model_key(ev_ext, ev_code, ev_pr);
        end
        repeat (8) @(posedge clk_sys);
        #1;
        famicom_latch = 1'b0;
        repeat (8) @(posedge clk_sys);
        #1;
        for (int p = 1; p <= 9; p++) begin
            famicom_pulse = 1'b1;
            repeat (8) @(posedge clk_sys);
            #1;
            famicom_pulse = 1'b0;
            if (p == rst_after) begin
                reset = 1'b1;
                @(posedge clk_sys); #1;
                reset = 1'b0;
                model_reset();
                @(negedge clk_sys);
                check_bit("reset_mid_shift_data", famicom_data, 1'b1);
            end
            repeat (8) @(posedge clk_sys);
            #1;
        end
    endtask

    // Monitor: collect each frame's serial samples and score against the queue.
    initial begin
        logic [9:0] obs;
        logic [9:0] e;
        forever begin
            @(posedge famicom_latch);
            @(negedge famicom_latch);
            repeat (6) @(negedge clk_sys);
            obs = {9'h000, famicom_data};
            for (int k = 1; k <= 9; k++) begin
                @(posedge famicom_pulse);
                repeat (6) @(negedge clk_sys);
                obs = {obs[8:0], famicom_data};
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame%0d unexpected, got %b with nothing expected", frame_no, obs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("FAIL frame%0d got %b expected %b", frame_no, obs, e);
                end
            end
            frame_no++;
        end
    end

    initial begin
        int r;
        logic [8:0] k;
        build_maps();
        model_reset();
        repeat (4) @(posedge clk_sys);
        #1;
        reset = 1'b0;
        @(negedge clk_sys);
        check_bit("reset_data", famicom_data, 1'b1);

        // Gamepad: X and Up held
        ascii_mode = 1'b0;
        send_key(0, 8'h22, 1);
        send_key(1, 8'h75, 1);
        run_frame(0, 0, 8'h00, 0, 0);
        send_key(0, 8'h22, 0);
        send_key(1, 8'h75, 0);
        run_frame(0, 0, 8'h00, 0, 0);

        // ASCII with shift: 'A' for HOLD latches then zero
        @(posedge clk_sys); #1;
        ascii_mode = 1'b1;
        send_key(0, 8'h12, 1);
        send_key(0, 8'h1C, 1);
        for (int i = 0; i < HOLD + 1; i++) run_frame(0, 0, 8'h00, 0, 0);
        send_key(0, 8'h1C, 0);
        send_key(0, 8'h12, 0);

        // Unmapped key leaves the pending code alone
        send_key(0, 8'h05, 1);
        run_frame(0, 0, 8'h00, 0, 0);
        send_key(0, 8'h05, 0);

        // New key during a hold restarts it
        send_key(0, 8'h16, 1);
        run_frame(0, 0, 8'h00, 0, 0);
        run_frame(0, 0, 8'h00, 0, 0);
        send_key(0, 8'h1E, 1);
        for (int i = 0; i < HOLD + 1; i++) run_frame(0, 0, 8'h00, 0, 0);
        send_key(0, 8'h16, 0);
        send_key(0, 8'h1E, 0);

        // Key event in the same cycle as the latch edge
        @(posedge clk_sys); #1;
        ascii_mode = 1'b0;
        run_frame(1, 0, 8'h1A, 1, 0);
        run_frame(0, 0, 8'h00, 0, 0);
        send_key(0, 8'h1A, 0);

        // Reset after the third pulse, then a clean frame
        send_key(0, 8'h22, 1);
        send_key(1, 8'h72, 1);
        run_frame(0, 0, 8'h00, 0, 3);
        run_frame(0, 0, 8'h00, 0, 0);

        // Randomized key traffic, mode changes and frames
        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                @(posedge clk_sys); #1;
                ascii_mode = ~ascii_mode;
            end else if (r < 65) begin
                k = pool[$urandom_range(0, 19)];
                if ($urandom_range(0, 9) == 0) k = 9'($urandom_range(0, 511));
                send_key(k[8], k[7:0], $urandom_range(0, 3) != 0);
            end else begin
                run_frame(0, 0, 8'h00, 0, 0);
            end
        end

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk_sys);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL frames_outstanding got %0d expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
